// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDWAIT,
        RESP
    } dmem_state_e;

    localparam logic PORT_MEM = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int unsigned DMEM_ADDR_WIDTH = 16;
    localparam int unsigned DMEM_DATA_WIDTH = 16;
    localparam int unsigned DMEM_DEPTH      = 256;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle of the data-memory arbiter.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH
);

    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  err0;
    logic                  err1;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_re;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, err0, err1,
               mem_addr, mem_wdata, mem_re, mem_we, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, err0, err1,
               mem_addr, mem_wdata, mem_re, mem_we, busy
    );

endinterface

// File: rtl/dmem_rr_picker.sv
// Combinational two-way grant: round-robin on contention, or fixed priority to port 0.
module dmem_rr_picker
    import dmem_pkg::*;
#(
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic req0_i,
    input  logic req1_i,
    input  logic prio_i,
    output logic gnt_valid_o,
    output logic gnt_port_o
);

    always_comb begin
        gnt_valid_o = req0_i | req1_i;
        gnt_port_o  = PORT_MEM;
        if (req0_i && req1_i) begin
            // prio_i names the port that was not served last
            gnt_port_o = (PRIORITY_MODE == 0) ? prio_i : PORT_MEM;
        end else if (req1_i) begin
            gnt_port_o = PORT_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises MEM-stage and debug-port accesses onto a 256x16 memory with
// one-cycle registered read latency; returns a one-cycle ack per access.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = DMEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH    = DMEM_DATA_WIDTH,
    parameter int unsigned DEPTH         = DMEM_DEPTH,
    parameter int unsigned PRIORITY_MODE = 0
) (
    input logic           clock,
    input logic           reset_n,
    dmem_arbiter_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    dmem_state_e           state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  port_q, port_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_re_q, mem_re_d;
    logic                  mem_we_q, mem_we_d;
    logic                  ack0_q, ack0_d, ack1_q, ack1_d;
    logic                  err0_q, err0_d, err1_q, err1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                  busy_q, busy_d;

    logic                  gnt_valid;
    logic                  gnt_port;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  in_range;
    logic                  resp_fire;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_data;

    dmem_rr_picker #(
        .PRIORITY_MODE(PRIORITY_MODE)
    ) u_picker (
        .req0_i     (bus.req0),
        .req1_i     (bus.req1),
        .prio_i     (prio_q),
        .gnt_valid_o(gnt_valid),
        .gnt_port_o (gnt_port)
    );

    assign sel_we    = (gnt_port == PORT_DBG) ? bus.we1    : bus.we0;
    assign sel_addr  = (gnt_port == PORT_DBG) ? bus.addr1  : bus.addr0;
    assign sel_wdata = (gnt_port == PORT_DBG) ? bus.wdata1 : bus.wdata0;
    assign in_range  = ({1'b0, sel_addr} < DEPTH_LIMIT);

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        port_d      = port_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        resp_fire   = 1'b0;
        resp_err    = 1'b0;
        resp_data   = '0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    port_d = gnt_port;
                    we_d   = sel_we;
                    prio_d = ~gnt_port;
                    if (!in_range) begin
                        resp_fire = 1'b1;
                        resp_err  = 1'b1;
                        state_d   = RESP;
                    end else begin
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = sel_wdata;
                        mem_re_d    = ~sel_we;
                        mem_we_d    = sel_we;
                        state_d     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    resp_fire = 1'b1;
                    state_d   = RESP;
                end else begin
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                resp_fire = 1'b1;
                resp_data = bus.mem_rdata;
                state_d   = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Response registers are loaded on the transition into RESP
        if (resp_fire) begin
            if (port_d == PORT_DBG) begin
                ack1_d   = 1'b1;
                err1_d   = resp_err;
                rdata1_d = resp_data;
            end else begin
                ack0_d   = 1'b1;
                err0_d   = resp_err;
                rdata0_d = resp_data;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            prio_q      <= PORT_MEM;
            port_q      <= PORT_MEM;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            port_q      <= port_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.err0      = err0_q;
    assign bus.err1      = err1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vectors, corner sequences and random traffic
// checked against a plain array model of the memory.
module tb_dmem_arbiter;

    logic clock = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus_rr ();
    dmem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus_fp ();

    dmem_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(256), .PRIORITY_MODE(0)
    ) dut_rr (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus_rr.slave)
    );

    dmem_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(256), .PRIORITY_MODE(1)
    ) dut_fp (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus_fp.slave)
    );

    // Memories with one-cycle registered read
    logic [15:0] rr_mem [256];
    logic [15:0] fp_mem [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            rr_mem[i] <= 16'h0;
            fp_mem[i] <= 16'h0;
        end
        fp_mem[0] <= 16'd10;
        fp_mem[1] <= 16'd5;
    end

    always @(posedge clock) begin
        if (bus_rr.mem_we) rr_mem[bus_rr.mem_addr[7:0]] <= bus_rr.mem_wdata;
        if (bus_rr.mem_re) bus_rr.mem_rdata <= rr_mem[bus_rr.mem_addr[7:0]];
        if (bus_fp.mem_we) fp_mem[bus_fp.mem_addr[7:0]] <= bus_fp.mem_wdata;
        if (bus_fp.mem_re) bus_fp.mem_rdata <= fp_mem[bus_fp.mem_addr[7:0]];
    end

    always @(negedge clock) begin
        if (bus_rr.mem_re && bus_rr.mem_we) begin
            errors++;
            $display("FAIL enable_exclusive_rr: re=%0b we=%0b required not both", bus_rr.mem_re, bus_rr.mem_we);
        end
        if ((bus_rr.mem_re || bus_rr.mem_we) && !bus_rr.busy) begin
            errors++;
            $display("FAIL enable_while_idle_rr: re=%0b we=%0b busy=0 required enables 0", bus_rr.mem_re, bus_rr.mem_we);
        end
        if (bus_fp.mem_re && bus_fp.mem_we) begin
            errors++;
            $display("FAIL enable_exclusive_fp: re=%0b we=%0b required not both", bus_fp.mem_re, bus_fp.mem_we);
        end
    end

    // Reference memory contents as seen by requesters
    logic [15:0] ref_mem [256];

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic p, input logic r, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
        if (p) begin
            bus_rr.req1 = r; bus_rr.we1 = w; bus_rr.addr1 = a; bus_rr.wdata1 = d;
        end else begin
            bus_rr.req0 = r; bus_rr.we0 = w; bus_rr.addr0 = a; bus_rr.wdata0 = d;
        end
    endtask

    function automatic logic get_ack(input int p);
        return (p == 1) ? bus_rr.ack1 : bus_rr.ack0;
    endfunction

    function automatic logic get_err(input int p);
        return (p == 1) ? bus_rr.err1 : bus_rr.err0;
    endfunction

    function automatic logic [15:0] get_rdata(input int p);
        return (p == 1) ? bus_rr.rdata1 : bus_rr.rdata0;
    endfunction

    function automatic logic [1:0] onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    task automatic run_vec(input vec_t v);
        int   n;
        bit   got;
        bit   saw_en;
        check("idle_before_vec", 32'(bus_rr.busy), 32'd0);
        set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
        n = 0; got = 0; saw_en = 0;
        while (!got && n < 10) begin
            @(negedge clock);
            n++;
            if (bus_rr.mem_re || bus_rr.mem_we) saw_en = 1;
            if (n == 1 && !v.err) begin
                check("vec_mem_we", 32'(bus_rr.mem_we), 32'(v.we));
                check("vec_mem_re", 32'(bus_rr.mem_re), 32'(!v.we));
                check("vec_mem_addr", 32'(bus_rr.mem_addr), 32'(v.addr));
                if (v.we) check("vec_mem_wdata", 32'(bus_rr.mem_wdata), 32'(v.wdata));
            end
            if (bus_rr.ack0 || bus_rr.ack1) begin
                got = 1;
                check("vec_latency", 32'(n), 32'(v.lat));
                check("vec_ack_port", 32'({bus_rr.ack1, bus_rr.ack0}), 32'(onehot(v.port)));
                check("vec_err", 32'({bus_rr.err1, bus_rr.err0}), 32'(v.err ? onehot(v.port) : 2'b00));
                check("vec_rdata", 32'(get_rdata(int'(v.port))), 32'(v.rdata));
            end
        end
        check("vec_ack_seen", 32'(got), 32'd1);
        if (v.err) check("vec_oor_no_mem_access", 32'(saw_en), 32'd0);
        if (v.we && !v.err) ref_mem[v.addr[7:0]] = v.wdata;
        set_req(v.port, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock);
        check("vec_ack_single_cycle", 32'({bus_rr.ack1, bus_rr.ack0}), 32'd0);
        check("vec_rdata_hold", 32'(get_rdata(int'(v.port))), 32'(v.rdata));
    endtask

    // Random-traffic requester state
    logic        pend    [2];
    logic        p_we    [2];
    logic [15:0] p_addr  [2];
    logic [15:0] p_wdata [2];
    int          waited  [2];
    int          age     [2];

    task automatic rand_step(input bit allow_issue);
        logic        exp_err;
        logic [15:0] exp_rd;
        int          r;
        @(negedge clock);
        for (int p = 0; p < 2; p++) begin
            if (get_ack(p)) begin
                check("rand_ack_expected", 32'(pend[p]), 32'd1);
                if (pend[p]) begin
                    exp_err = (p_addr[p] > 16'h00FF);
                    exp_rd  = (p_we[p] || exp_err) ? 16'h0 : ref_mem[p_addr[p][7:0]];
                    check("rand_err", 32'(get_err(p)), 32'(exp_err));
                    check("rand_rdata", 32'(get_rdata(p)), 32'(exp_rd));
                    check("rand_fair_wait", 32'(waited[p] <= 1), 32'd1);
                    if (p_we[p] && !exp_err) ref_mem[p_addr[p][7:0]] = p_wdata[p];
                    pend[p] = 1'b0;
                    set_req(1'(p), 1'b0, 1'b0, 16'h0, 16'h0);
                    if (pend[1-p]) waited[1-p]++;
                end
            end else if (pend[p]) begin
                age[p]++;
                if (age[p] > 30) begin
                    check("rand_ack_timeout", 32'd0, 32'd1);
                    pend[p] = 1'b0;
                    set_req(1'(p), 1'b0, 1'b0, 16'h0, 16'h0);
                end
            end
        end
        if (allow_issue) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 3) == 0) begin
                    r          = int'($urandom_range(0, 19));
                    p_we[p]    = 1'($urandom_range(0, 1));
                    p_addr[p]  = (r == 0) ? 16'($urandom) :
                                 (r == 1) ? 16'h0100 :
                                 (r == 2) ? 16'h00FF : 16'($urandom_range(0, 7));
                    p_wdata[p] = 16'($urandom);
                    pend[p]    = 1'b1;
                    waited[p]  = 0;
                    age[p]     = 0;
                    set_req(1'(p), 1'b1, p_we[p], p_addr[p], p_wdata[p]);
                end
            end
        end
    endtask

    initial begin
        int acks;
        int cyc;
        logic exp_port;

        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; waited[p] = 0; age[p] = 0;
        end

        vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'h1234, 2, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 3, 16'h1234, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'h0000, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 16'h00FF, 16'hBEEF, 2, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'h01FF, 16'hDEAD, 1, 16'h0000, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 3, 16'hBEEF, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0000, 16'h000A, 2, 16'h0000, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 16'h0001, 16'h0005, 2, 16'h0000, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1, 16'h0000, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 3, 16'h0005, 1'b0};

        // Reset held with a pending request
        reset_n = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        bus_fp.req0 = 1'b1; bus_fp.we0 = 1'b0; bus_fp.addr0 = 16'h0; bus_fp.wdata0 = 16'h0;
        bus_fp.req1 = 1'b0; bus_fp.we1 = 1'b0; bus_fp.addr1 = 16'h0; bus_fp.wdata1 = 16'h0;
        repeat (2) begin
            @(negedge clock);
            check("reset_outputs_rr", 32'(|{bus_rr.ack0, bus_rr.ack1, bus_rr.err0, bus_rr.err1,
                  bus_rr.rdata0, bus_rr.rdata1, bus_rr.mem_addr, bus_rr.mem_wdata,
                  bus_rr.mem_re, bus_rr.mem_we, bus_rr.busy}), 32'd0);
            check("reset_outputs_fp", 32'(|{bus_fp.ack0, bus_fp.ack1, bus_fp.err0, bus_fp.err1,
                  bus_fp.rdata0, bus_fp.rdata1, bus_fp.mem_addr, bus_fp.mem_wdata,
                  bus_fp.mem_re, bus_fp.mem_we, bus_fp.busy}), 32'd0);
        end
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        bus_fp.req0 = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        check("post_reset_idle", 32'({bus_rr.busy, bus_rr.ack0, bus_rr.ack1}), 32'd0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset during RDWAIT; the last grant went to port 0, so reset must restore port-0 preference
        set_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        @(negedge clock);
        @(negedge clock);
        check("midop_in_rdwait", 32'({bus_rr.busy, bus_rr.mem_re, bus_rr.ack0}), 32'b100);
        reset_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock);
        check("midop_no_ack", 32'({bus_rr.ack0, bus_rr.ack1}), 32'd0);
        check("midop_idle", 32'(bus_rr.busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Round-robin contention: port 0 first, then strict alternation
        set_req(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0);
        set_req(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0);
        exp_port = 1'b0; acks = 0; cyc = 0;
        while (acks < 6 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (bus_rr.ack0 || bus_rr.ack1) begin
                check("rr_ack_port", 32'({bus_rr.ack1, bus_rr.ack0}), 32'(onehot(exp_port)));
                check("rr_rdata", 32'(get_rdata(int'(exp_port))), exp_port ? 32'd5 : 32'd10);
                exp_port = ~exp_port;
                acks++;
            end
        end
        check("rr_ack_count", 32'(acks), 32'd6);
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock);

        // Fixed priority: port 1 only after port 0 drops
        bus_fp.req0 = 1'b1; bus_fp.we0 = 1'b0; bus_fp.addr0 = 16'h0000;
        bus_fp.req1 = 1'b1; bus_fp.we1 = 1'b0; bus_fp.addr1 = 16'h0001;
        acks = 0; cyc = 0;
        while (acks < 5 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (bus_fp.ack0 || bus_fp.ack1) begin
                if (acks < 4) begin
                    check("fp_ack_port", 32'({bus_fp.ack1, bus_fp.ack0}), 32'b01);
                    check("fp_rdata0", 32'(bus_fp.rdata0), 32'd10);
                end else begin
                    check("fp_ack_port", 32'({bus_fp.ack1, bus_fp.ack0}), 32'b10);
                    check("fp_rdata1", 32'(bus_fp.rdata1), 32'd5);
                    bus_fp.req1 = 1'b0;
                end
                acks++;
                if (acks == 4) bus_fp.req0 = 1'b0;
            end
        end
        check("fp_ack_count", 32'(acks), 32'd5);
        bus_fp.req0 = 1'b0;
        bus_fp.req1 = 1'b0;

        // Random mixed traffic from both ports
        for (int c = 0; c < 1000; c++) rand_step(1'b1);
        for (int i = 0; i < 80 && (pend[0] || pend[1]); i++) rand_step(1'b0);
        check("rand_drained", 32'(pend[0] | pend[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the 256x16 data memory between two requesters: port 0 is the pipeline MEM stage, port 1 is the debug/loader port.
- Serialises one access at a time and drives the memory's read-enable, write-enable, address and write-data inputs.
- Aligns the memory's one-cycle registered read latency and returns a single-cycle done/acknowledge to the requester that was served.
- Sits between the MEM stage and the data memory; the memory's output bus feeds mem_rdata.

Parameters:
- ADDR_WIDTH, 16, requester and memory address width.
- DATA_WIDTH, 16, data word width.
- DEPTH, 256, number of valid memory cells; addresses >= DEPTH are rejected.
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority to port 0.

Ports:
- clock  in  1  single system clock; all logic on posedge.
- reset_n  in  1  synchronous reset, active-low.
- req0, req1  in  1 each  request valid; held high with fields stable until the matching ack.
- we0, we1  in  1 each  1 = write, 0 = read.
- addr0, addr1  in  ADDR_WIDTH each  access address.
- wdata0, wdata1  in  DATA_WIDTH each  write data.
- ack0, ack1  out  1 each  one-cycle completion pulse.
- rdata0, rdata1  out  DATA_WIDTH each  read data; valid while ackN is high.
- err0, err1  out  1 each  high with ackN when the address was out of range.
- mem_addr  out  ADDR_WIDTH  to memory address bus.
- mem_wdata  out  DATA_WIDTH  to memory input bus.
- mem_re  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_WIDTH  memory output bus (registered in the memory, one-cycle latency).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered. When reset_n = 0 at a posedge, every output goes to 0, the FSM goes to IDLE, the round-robin pointer goes to port 0, and any in-flight transaction is dropped with no ack.
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, request present:
  - Arbitrate and latch port id, we, addr and wdata.
  - addr >= DEPTH: go to RESP with err flagged; the memory is never touched.
  - Otherwise: drive mem_addr, mem_wdata and mem_re or mem_we (registered, active during the next cycle), then go to ACCESS.
- ACCESS: the memory performs the operation at the end of this cycle.
  - Write: deassert enables, go to RESP.
  - Read: deassert enables, go to RDWAIT.
- RDWAIT: capture mem_rdata into the served port's rdata register, go to RESP.
- RESP: ackN = 1 for exactly this cycle, errN as latched, rdataN valid; return to IDLE.
- Latency, counted from the IDLE cycle T in which the request is sampled:
  - Write ack in T+2.
  - Read ack in T+3.
  - Out-of-range ack in T+1.
  - Next arbitration at the earliest in the cycle after RESP.
- mem_re and mem_we are never high in the same cycle. Both are 0 in every state other than ACCESS.
- Arbitration:
  - PRIORITY_MODE=1: port 0 always wins.
  - PRIORITY_MODE=0, both requesting: the port not served last wins. The pointer updates only when a grant is issued; a lone requester always wins.
- rdataN holds its last value outside ack. On write or err acks, rdataN = 0.
- Requester protocol violation (req dropped or fields changed before ack): the latched transaction completes unchanged and ack is still issued.
- Address compare is unsigned on the full ADDR_WIDTH; mem_addr carries the full address.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum (IDLE, ACCESS, RDWAIT, RESP);
  - port id constants PORT_MEM = 0, PORT_DBG = 1;
  - default DEPTH/width constants.
- One natural sub-module: dmem_rr_picker, the combinational two-way grant from req0/req1, last-served pointer and PRIORITY_MODE. The FSM stays in dmem_arbiter.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles with req0 = 1 -> all outputs 0, busy = 0, mem_re = mem_we = 0; no ack until reset_n = 1.
- Single write then read, port 0:
  - write addr 0x0010, data 0x1234 -> mem_we high in T+1 with mem_addr = 0x0010, ack0 in T+2.
  - read 0x0010 -> mem_re in T+1, ack0 in T+3 with rdata0 = 0x1234, err0 = 0.
- Contention, PRIORITY_MODE=0: req0 and req1 both asserted continuously (reads of 0 and 1, preloaded 10 and 5) -> acks alternate ack0, ack1, ack0, ... with rdata 10/5; no port waits more than one transaction. PRIORITY_MODE=1 -> only ack0 until req0 drops.
- Out-of-range: read addr 0x0100 on port 1 -> ack1 and err1 in T+1, rdata1 = 0, mem_re/mem_we never asserted; memory contents unchanged.
- Reset mid-operation: assert reset_n = 0 during RDWAIT -> no ack issued, FSM in IDLE, pointer at port 0. The next request completes normally.
- Enable exclusivity: random mixed traffic for 1000 cycles -> assertion never sees mem_re & mem_we, and a scoreboard model of the memory matches every rdata.
